// File: rtl/branch_redirect_arbiter.sv
// Branch redirect arbiter: picks the oldest live mispredicting branch across
// CHANNELS ALU result ports and issues one registered redirect. A pending
// redirect is held until commit_flush and suppresses younger mispredicts.
module branch_redirect_arbiter #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned ROB_WIDTH   = 6,
  parameter int unsigned FSQ_WIDTH   = 5,
  parameter int unsigned VADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CHANNELS-1:0]                  br_en,
  input  logic [CHANNELS-1:0]                  br_mispred,
  input  logic [CHANNELS*(ROB_WIDTH+1)-1:0]    br_rob_idx,
  input  logic [CHANNELS*FSQ_WIDTH-1:0]        br_fsq_idx,
  input  logic [CHANNELS*VADDR_WIDTH-1:0]      br_target,
  input  logic                                 ext_redirect,
  input  logic [ROB_WIDTH:0]                   ext_redirect_idx,
  input  logic                                 commit_flush,
  output logic                                 redirect_valid,
  output logic [ROB_WIDTH:0]                   redirect_rob_idx,
  output logic [FSQ_WIDTH-1:0]                 redirect_fsq_idx,
  output logic [VADDR_WIDTH-1:0]               redirect_target,
  output logic                                 pending,
  output logic [CNT_WIDTH-1:0]                 mispred_cnt
);

  localparam int unsigned AW     = ROB_WIDTH + 1;
  localparam int unsigned CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned LEAVES = (CHANNELS > 1) ? (32'd1 << $clog2(CHANNELS)) : 32'd1;
  localparam int unsigned NODES  = 2 * LEAVES - 1;

  typedef enum logic {IDLE, PENDING} state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          pend_idx_q, pend_idx_d;
  logic                   rv_q, rv_d;
  logic [AW-1:0]          rob_q, rob_d;
  logic [FSQ_WIDTH-1:0]   fsq_q, fsq_d;
  logic [VADDR_WIDTH-1:0] tgt_q, tgt_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  // Heap-ordered comparison tree: node 0 is the root, leaves start at LEAVES-1.
  logic                   node_vld [NODES];
  logic [AW-1:0]          node_age [NODES];
  logic [CW-1:0]          node_ch  [NODES];

  logic                   win;
  logic [AW-1:0]          win_age;
  logic [CW-1:0]          win_ch;
  logic [FSQ_WIDTH-1:0]   win_fsq;
  logic [VADDR_WIDTH-1:0] win_tgt;

  // a is strictly older than b; the MSB flips on each ROB wrap
  function automatic logic older(input logic [AW-1:0] a, input logic [AW-1:0] b);
    if (a[AW-1] == b[AW-1]) return a[AW-2:0] < b[AW-2:0];
    else                    return a[AW-2:0] > b[AW-2:0];
  endfunction

  // Build leaves from live candidates and reduce to the oldest; ties keep the left (lower channel) side
  always_comb begin
    for (int unsigned n = 0; n < NODES; n++) begin
      node_vld[n] = 1'b0;
      node_age[n] = '0;
      node_ch[n]  = '0;
    end
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      node_age[LEAVES-1+c] = br_rob_idx[c*AW +: AW];
      node_ch[LEAVES-1+c]  = CW'(c);
      node_vld[LEAVES-1+c] = br_en[c] & br_mispred[c]
                           & (~ext_redirect | older(br_rob_idx[c*AW +: AW], ext_redirect_idx))
                           & ((state_q == IDLE) | older(br_rob_idx[c*AW +: AW], pend_idx_q));
    end
    for (int unsigned k = 0; k + 1 < LEAVES; k++) begin
      int unsigned i;
      int unsigned l;
      int unsigned r;
      logic take_r;
      i = LEAVES - 2 - k;
      l = 2 * i + 1;
      r = 2 * i + 2;
      take_r = node_vld[r] & (~node_vld[l] | older(node_age[r], node_age[l]));
      node_vld[i] = node_vld[l] | node_vld[r];
      node_age[i] = take_r ? node_age[r] : node_age[l];
      node_ch[i]  = take_r ? node_ch[r]  : node_ch[l];
    end
    win     = node_vld[0];
    win_age = node_age[0];
    win_ch  = node_ch[0];
  end

  // Fetch FSQ entry and target of the winning channel
  always_comb begin
    win_fsq = '0;
    win_tgt = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (win_ch == CW'(c)) begin
        win_fsq = br_fsq_idx[c*FSQ_WIDTH +: FSQ_WIDTH];
        win_tgt = br_target[c*VADDR_WIDTH +: VADDR_WIDTH];
      end
    end
  end

  // Next state: redirect outputs, saturating counter and pending FSM
  always_comb begin
    state_d    = state_q;
    pend_idx_d = pend_idx_q;
    rv_d       = 1'b0;
    rob_d      = rob_q;
    fsq_d      = fsq_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    if (win) begin
      rv_d  = 1'b1;
      rob_d = win_age;
      fsq_d = win_fsq;
      tgt_d = win_tgt;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (win) begin
          state_d    = PENDING;
          pend_idx_d = win_age;
        end
      end
      PENDING: begin
        // a winner here is already older than pend_idx_q, so it always reloads
        if (win) begin
          pend_idx_d = win_age;
        end else if (commit_flush) begin
          state_d = IDLE;
        end else if (ext_redirect && older(ext_redirect_idx, pend_idx_q)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_idx_q <= '0;
      rv_q       <= 1'b0;
      rob_q      <= '0;
      fsq_q      <= '0;
      tgt_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_idx_q <= pend_idx_d;
      rv_q       <= rv_d;
      rob_q      <= rob_d;
      fsq_q      <= fsq_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
    end
  end

  assign redirect_valid   = rv_q;
  assign redirect_rob_idx = rob_q;
  assign redirect_fsq_idx = fsq_q;
  assign redirect_target  = tgt_q;
  assign pending          = (state_q == PENDING);
  assign mispred_cnt      = cnt_q;

endmodule

// File: tb/tb_branch_redirect_arbiter.sv
// Scoreboard bench for branch_redirect_arbiter: a reference model pushes the
// expected post-edge outputs each cycle, popped and compared after the edge.
module tb_branch_redirect_arbiter;

  localparam int unsigned C  = 4;
  localparam int unsigned RW = 6;
  localparam int unsigned AW = RW + 1;
  localparam int unsigned FW = 5;
  localparam int unsigned VW = 32;
  localparam int unsigned NW = 2;

  logic              clk;
  logic              rst;
  logic [C-1:0]      br_en;
  logic [C-1:0]      br_mispred;
  logic [C*AW-1:0]   br_rob_idx;
  logic [C*FW-1:0]   br_fsq_idx;
  logic [C*VW-1:0]   br_target;
  logic              ext_redirect;
  logic [AW-1:0]     ext_redirect_idx;
  logic              commit_flush;
  logic              redirect_valid;
  logic [AW-1:0]     redirect_rob_idx;
  logic [FW-1:0]     redirect_fsq_idx;
  logic [VW-1:0]     redirect_target;
  logic              pending;
  logic [NW-1:0]     mispred_cnt;

  branch_redirect_arbiter #(
    .CHANNELS(C), .ROB_WIDTH(RW), .FSQ_WIDTH(FW), .VADDR_WIDTH(VW), .CNT_WIDTH(NW)
  ) dut (
    .clk(clk), .rst(rst), .br_en(br_en), .br_mispred(br_mispred),
    .br_rob_idx(br_rob_idx), .br_fsq_idx(br_fsq_idx), .br_target(br_target),
    .ext_redirect(ext_redirect), .ext_redirect_idx(ext_redirect_idx),
    .commit_flush(commit_flush), .redirect_valid(redirect_valid),
    .redirect_rob_idx(redirect_rob_idx), .redirect_fsq_idx(redirect_fsq_idx),
    .redirect_target(redirect_target), .pending(pending), .mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [AW-1:0] rob;
    logic [FW-1:0] fsq;
    logic [VW-1:0] tgt;
    logic          pend;
    logic [NW-1:0] cnt;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic          m_pend;
  logic [AW-1:0] m_pidx;
  logic [AW-1:0] m_rob;
  logic [FW-1:0] m_fsq;
  logic [VW-1:0] m_tgt;
  logic [NW-1:0] m_cnt;

  function automatic bit m_older(input logic [AW-1:0] a, input logic [AW-1:0] b);
    if (a[AW-1] == b[AW-1]) return a[AW-2:0] < b[AW-2:0];
    return a[AW-2:0] > b[AW-2:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic clr();
    br_en = '0; br_mispred = '0; br_rob_idx = '0; br_fsq_idx = '0; br_target = '0;
    ext_redirect = 1'b0; ext_redirect_idx = '0; commit_flush = 1'b0;
  endtask

  task automatic br(input int ch, input logic [AW-1:0] rob, input logic [FW-1:0] fsq,
                    input logic [VW-1:0] tgt);
    br_en[ch] = 1'b1;
    br_mispred[ch] = 1'b1;
    br_rob_idx[ch*AW +: AW] = rob;
    br_fsq_idx[ch*FW +: FW] = fsq;
    br_target[ch*VW +: VW] = tgt;
  endtask

  // Model the current cycle, push expectation, clock, then pop and compare
  task automatic step(input string tag);
    exp_t e;
    exp_t got;
    int best;
    logic [AW-1:0] bage;
    logic [AW-1:0] age;
    bit live;
    best = -1;
    bage = '0;
    if (rst) begin
      m_pend = 0; m_pidx = '0; m_rob = '0; m_fsq = '0; m_tgt = '0; m_cnt = '0;
      e.v = 0;
    end else begin
      for (int c = 0; c < C; c++) begin
        age  = br_rob_idx[c*AW +: AW];
        live = br_en[c] && br_mispred[c]
            && (!ext_redirect || m_older(age, ext_redirect_idx))
            && (!m_pend || m_older(age, m_pidx));
        if (live && (best < 0 || m_older(age, bage))) begin
          best = c;
          bage = age;
        end
      end
      e.v = (best >= 0);
      if (best >= 0) begin
        m_rob = bage;
        m_fsq = br_fsq_idx[best*FW +: FW];
        m_tgt = br_target[best*VW +: VW];
        if (m_cnt != 2'b11) m_cnt = m_cnt + 2'd1;
        m_pend = 1; m_pidx = bage;
      end else if (m_pend && commit_flush) begin
        m_pend = 0;
      end else if (m_pend && ext_redirect && m_older(ext_redirect_idx, m_pidx)) begin
        m_pend = 0;
      end
    end
    e.rob = m_rob; e.fsq = m_fsq; e.tgt = m_tgt; e.pend = m_pend; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({tag, ".valid"}, 64'(redirect_valid), 64'(got.v));
    check({tag, ".rob"},   64'(redirect_rob_idx), 64'(got.rob));
    check({tag, ".fsq"},   64'(redirect_fsq_idx), 64'(got.fsq));
    check({tag, ".tgt"},   64'(redirect_target), 64'(got.tgt));
    check({tag, ".pend"},  64'(pending), 64'(got.pend));
    check({tag, ".cnt"},   64'(mispred_cnt), 64'(got.cnt));
  endtask

  initial begin
    logic [AW-1:0] base;
    clr();
    rst = 1'b1;
    step("reset0");
    step("reset1");
    rst = 1'b0;

    clr(); br(2, 7'h05, 5'd3, 32'h8000_0100); step("single");
    check("single.direct_rob", 64'(redirect_rob_idx), 64'h05);
    check("single.direct_tgt", 64'(redirect_target), 64'h8000_0100);
    clr(); commit_flush = 1'b1; step("commit1");

    clr(); br(0, 7'h0A, 5'd1, 32'hA); br(1, 7'h03, 5'd2, 32'hB); br(3, 7'h07, 5'd4, 32'hC);
    step("oldest");
    check("oldest.direct_rob", 64'(redirect_rob_idx), 64'h03);
    clr(); commit_flush = 1'b1; step("commit2");

    clr(); br(0, 7'h41, 5'd5, 32'h100); br(1, 7'h3E, 5'd6, 32'h200); step("wrap");
    check("wrap.direct_rob", 64'(redirect_rob_idx), 64'h3E);
    clr(); commit_flush = 1'b1; step("commit3");
    clr(); br(0, 7'h40, 5'd7, 32'h300); br(1, 7'h3F, 5'd8, 32'h400); step("wrap_edge");
    clr(); commit_flush = 1'b1; step("commit4");

    clr(); br(0, 7'h10, 5'd9, 32'h500); step("pend_set");
    clr(); br(1, 7'h12, 5'd10, 32'h600); step("pend_younger");
    clr(); br(2, 7'h10, 5'd11, 32'h700); step("pend_equal");
    clr(); br(2, 7'h0C, 5'd12, 32'h800); step("pend_older");
    check("pend_older.direct_rob", 64'(redirect_rob_idx), 64'h0C);
    clr(); commit_flush = 1'b1; step("pend_commit");
    check("pend_commit.direct", 64'(pending), 64'h0);

    clr(); ext_redirect = 1'b1; ext_redirect_idx = 7'h08;
    br(0, 7'h09, 5'd13, 32'h900); br(3, 7'h06, 5'd14, 32'hA00); step("ext_both");
    clr(); commit_flush = 1'b1; step("commit5");
    clr(); ext_redirect = 1'b1; ext_redirect_idx = 7'h08;
    br(1, 7'h09, 5'd15, 32'hB00); step("ext_only_young");

    clr(); br(0, 7'h20, 5'd16, 32'hC00); step("ext_pend_set");
    clr(); ext_redirect = 1'b1; ext_redirect_idx = 7'h10; step("ext_pend_clear");
    clr(); br(0, 7'h20, 5'd17, 32'hD00); step("cf_set");
    clr(); commit_flush = 1'b1; br(2, 7'h15, 5'd18, 32'hE00); step("cf_with_winner");
    clr(); commit_flush = 1'b1; br(2, 7'h25, 5'd19, 32'hF00); step("cf_younger");

    clr(); br(3, 7'h30, 5'd20, 32'h1100); br(1, 7'h30, 5'd21, 32'h1200); step("tie");
    clr(); commit_flush = 1'b1; step("commit6");

    clr(); br(0, 7'h50, 5'd22, 32'h1300); step("rst_pend_set");
    clr(); rst = 1'b1; br(1, 7'h01, 5'd23, 32'h1400); step("rst_mid");
    rst = 1'b0;
    clr(); step("after_rst");

    base = 7'h00;
    for (int n = 0; n < 200; n++) begin
      clr();
      if (n % 16 == 15) base = base + 7'd1;
      for (int c = 0; c < C; c++) begin
        br_en[c]      = 1'($urandom_range(0, 1));
        br_mispred[c] = 1'($urandom_range(0, 1));
        br_rob_idx[c*AW +: AW] = base + 7'($urandom_range(0, 31));
        br_fsq_idx[c*FW +: FW] = 5'($urandom);
        br_target[c*VW +: VW]  = $urandom;
      end
      ext_redirect     = ($urandom_range(0, 4) == 0);
      ext_redirect_idx = base + 7'($urandom_range(0, 31));
      commit_flush     = ($urandom_range(0, 3) == 0);
      rst              = ($urandom_range(0, 49) == 0);
      step("random");
    end
    rst = 1'b0;
    clr();
    step("drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_redirect_arbiter.md
# branch_redirect_arbiter

Parametrised arbiter that collects branch resolutions from `CHANNELS` ALU ports, selects the oldest mispredicting branch by ROB age, and issues a single registered redirect to the frontend and backend flush logic. It sits between the ALU execute lanes and the backend redirect path. It generalises single-lane redirect selection: configurable channel count, configurable ROB and FSQ widths, and a held pending redirect that suppresses younger mispredicts until the flush commits. It also drops candidates squashed by an external redirect and keeps a saturating mispredict counter.

## Interface
Parameters:
- `CHANNELS`, 4: number of ALU result ports (1..8).
- `ROB_WIDTH`, 6: ROB index bits; age fields are `ROB_WIDTH+1` bits, with the MSB as the wrap/direction bit.
- `FSQ_WIDTH`, 5: FSQ index bits.
- `VADDR_WIDTH`, 32: redirect target width.
- `CNT_WIDTH`, 16: mispredict counter width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `br_en` in CHANNELS: branch result valid, per channel.
- `br_mispred` in CHANNELS: mispredict flag, per channel.
- `br_rob_idx` in CHANNELS×(ROB_WIDTH+1): ROB age of the branch.
- `br_fsq_idx` in CHANNELS×FSQ_WIDTH: FSQ entry of the branch.
- `br_target` in CHANNELS×VADDR_WIDTH: corrected target.
- `ext_redirect` in 1: external redirect (exception/replay) this cycle.
- `ext_redirect_idx` in ROB_WIDTH+1: age of the external redirect.
- `commit_flush` in 1: ROB has committed the flush; clears the pending redirect.
- `redirect_valid` out 1: one-cycle redirect pulse.
- `redirect_rob_idx` out ROB_WIDTH+1: age of the redirecting branch.
- `redirect_fsq_idx` out FSQ_WIDTH: FSQ entry of the redirecting branch.
- `redirect_target` out VADDR_WIDTH: redirect target.
- `pending` out 1: an issued redirect is awaiting `commit_flush`.
- `mispred_cnt` out CNT_WIDTH: saturating count of issued redirects.

## Operation
- Age rule: `older(a,b) = (a[MSB]==b[MSB]) ? a[ROB_WIDTH-1:0] < b[ROB_WIDTH-1:0] : a[ROB_WIDTH-1:0] > b[ROB_WIDTH-1:0]`. Equal ages are not older.
- Candidate i is live when all of the following hold:
  - `br_en[i] & br_mispred[i]`;
  - `~ext_redirect | older(br_rob_idx[i], ext_redirect_idx)`;
  - `~pend_q | older(br_rob_idx[i], pend_idx_q)`.
- Selection: a log2 comparison tree picks the oldest live candidate. On equal age, the lower channel index wins.
- Pending register (`pend_q`, `pend_idx_q`). Update priority, highest first:
  1. rst clears it.
  2. `commit_flush` clears it, and a live candidate in the same cycle is still taken and sets it again.
  3. A live winner loads it.
  4. `ext_redirect` with an idx older than `pend_idx_q` clears it.
- States: IDLE (`pend_q=0`) and PENDING (`pend_q=1`).
  - IDLE→PENDING on a live winner.
  - PENDING→PENDING (reload, re-issue) on an older live winner.
  - PENDING→IDLE on `commit_flush` without a winner, or on an older `ext_redirect`.
- `mispred_cnt` increments on each `redirect_valid` and saturates at all-ones.

## Timing
- Latency 1: a winner at cycle t gives `redirect_valid=1` with its fields at t+1. `redirect_valid` is high for exactly one cycle per winner.
- Back-to-back: a strictly older winner at t+1 gives a second pulse at t+2. A younger or equal-age winner gives no pulse.
- Outputs are fully registered, with no combinational input→output path.
- Reset values: `redirect_valid=0`, `redirect_rob_idx=0`, `redirect_fsq_idx=0`, `redirect_target=0`, `pending=0`, `mispred_cnt=0`.
- `rst` asserted mid-PENDING:
  - next cycle is IDLE with all outputs at their reset values;
  - an in-flight winner from the reset cycle is discarded.
- Wrap-around: ages 0x3F (MSB 0) vs 0x40 (MSB 1) with ROB_WIDTH=6 are compared by the age rule. 0x40 is not older than 0x3F.

## Test plan
- Single mispredict: ch2 has en, mispred, rob=0x05, fsq=3, target=0x8000_0100 at t. Required: at t+1 `redirect_valid=1` with rob=0x05, fsq=3, target=0x8000_0100, and `pending=1`, `mispred_cnt=1`.
- Oldest select: ch0 rob=0x0A, ch1 rob=0x03, ch3 rob=0x07, all mispredicting. Required: redirect with rob=0x03 from ch1; the others are dropped.
- Wrap age: ch0 rob=0x41, ch1 rob=0x3E. Required: ch1 wins (0x3E is older across the wrap).
- Pending suppression: pending at rob=0x10. A mispredict at rob=0x12 gives no pulse. A mispredict at rob=0x0C pulses and sets `pending` idx to 0x0C. `commit_flush` then gives `pending=0`.
- External squash: `ext_redirect` with idx=0x08 in the same cycle as mispredicts at rob=0x09 and rob=0x06. Required: redirect for 0x06 only. If 0x09 alone, no pulse.
- Saturation/reset: with CNT_WIDTH=2, four redirects hold `mispred_cnt=3`. `rst` while pending gives all outputs 0 the next cycle.
